gate_sweep_sequencer: RTL and testbench

Exhaustive stimulus-and-capture sequencer for a 2-input combinational gate (and_gate, or_gate, etc.). It drives the gate's A/B inputs through all four input combinations, holds each for a programmable number of cycles, and samples the gate's X output into a 4-bit truth-table register. It then flags pass/fail against an expected table. The block sits directly upstream of the gate under test, drives its inputs, and consumes its output, so gates can be checked in hardware without a testbench driver.

---
 rtl/gate_sweep_sequencer_pkg.sv | 36 +++
 rtl/gate_sweep_sequencer_hold_timer.sv | 52 +++++
 rtl/gate_sweep_sequencer.sv | 143 ++++++++++++++
 tb/tb_gate_sweep_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_sequencer_pkg.sv
// ============================================================================
// gate_sweep_sequencer_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the gate sweep sequencer:
//   - sequencer state encoding (2-bit: IDLE=0, DRIVE=1, REPORT=2)
//   - truth-table constants for the 2-input gate family, bit index {B,A}
//   - hold-timer width and reload helper
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_sweep_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // Truth tables indexed by {B,A}: bit 0 is A=0,B=0 ... bit 3 is A=1,B=1.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  localparam int TIMER_W = 8;

  // The timer counts the remaining cycles after the current one, so a
  // window of N cycles is loaded as N-1.
  function automatic logic [TIMER_W-1:0] hold_reload(input int unsigned hold);
    return TIMER_W'(hold - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_sweep_sequencer_hold_timer.sv
// ============================================================================
// hold_timer
// ----------------------------------------------------------------------------
// Down-counter with synchronous load and decrement, plus a zero flag.
// Load has priority over decrement; decrement saturates at zero.
// Ports:
//   clk_i       in   clock, rising edge
//   rst_ni      in   asynchronous active-low reset
//   load_i      in   load load_val_i on the next edge
//   load_val_i  in   value to load
//   dec_i       in   decrement on the next edge (ignored when zero)
//   zero_o      out  counter currently equals zero
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_timer
  import gate_sweep_sequencer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/gate_sweep_sequencer.sv
// ============================================================================
// gate_sweep_sequencer
// ----------------------------------------------------------------------------
// Drives a 2-input combinational gate through (A,B) = 00, 10, 01, 11, holds
// each vector for HOLD_CYCLES cycles, samples the gate output X on the last
// edge of each window into TRUTH[{B,A}], then reports TRUTH == EXPECTED.
// Parameters:
//   HOLD_CYCLES  cycles per vector, legal range 1..255
//   EXPECTED     expected truth table, bit index {B,A}
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   start_i  in   begin a sweep (only looked at in IDLE)
//   x_i      in   gate-under-test output, synchronous to clk_i
//   a_o      out  gate input A
//   b_o      out  gate input B
//   busy_o   out  high while vectors are being driven
//   done_o   out  one-cycle pulse when the sweep completes
//   pass_o   out  TRUTH == EXPECTED, valid from DONE until the next start
//   truth_o  out  captured truth table, bit index {B,A}
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sweep_sequencer
  import gate_sweep_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter logic [3:0]  EXPECTED    = TT_AND
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       x_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] truth_o
);

  localparam logic [TIMER_W-1:0] RELOAD = hold_reload(HOLD_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] idx_q,   idx_d;
  logic [3:0] truth_q, truth_d;
  logic       pass_q,  pass_d;

  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_zero;

  hold_timer u_hold_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (RELOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    truth_d  = truth_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_DRIVE;
          idx_d    = 2'd0;
          truth_d  = 4'b0000;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end

      ST_DRIVE: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          // Last cycle of this vector's window: X has settled from the
          // registered A/B, so capture it on this edge.
          truth_d[idx_q] = x_i;
          if (idx_q == 2'd3) begin
            state_d = ST_REPORT;
            // Compare against the table including the bit captured now,
            // since truth_q does not yet hold it.
            pass_d  = ({x_i, truth_q[2:0]} == EXPECTED);
          end else begin
            idx_d    = idx_q + 2'd1;
            tmr_load = 1'b1;
          end
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      truth_q <= 4'b0000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      truth_q <= truth_d;
      pass_q  <= pass_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from registers only, so A/B are glitch-free for the gate
  // --------------------------------------------------------------------------
  assign busy_o  = (state_q == ST_DRIVE);
  assign done_o  = (state_q == ST_REPORT);
  assign a_o     = busy_o & idx_q[0];
  assign b_o     = busy_o & idx_q[1];
  assign pass_o  = pass_q;
  assign truth_o = truth_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_sequencer.sv
// ============================================================================
// tb_gate_sweep_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for gate_sweep_sequencer. Two instances share clock and
// reset: one with HOLD_CYCLES=10, one with HOLD_CYCLES=1, both EXPECTED=AND.
// Each drives a modelled gate whose truth table is chosen per scenario.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sweep_sequencer;

  localparam logic [3:0] T_AND = 4'b1000;
  localparam logic [3:0] T_OR  = 4'b1110;
  localparam logic [3:0] T_XOR = 4'b0110;

  logic clk = 1'b0;
  logic rst_n;

  logic       start10, start1;
  logic [3:0] tbl10, tbl1;
  logic       x10, x1;
  logic       a10, b10, busy10, done10, pass10;
  logic       a1,  b1,  busy1,  done1,  pass1;
  logic [3:0] truth10, truth1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gates under test: combinational lookup of the chosen truth table.
  assign x10 = tbl10[{b10, a10}];
  assign x1  = tbl1[{b1, a1}];

  gate_sweep_sequencer #(.HOLD_CYCLES(10), .EXPECTED(T_AND)) dut10 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start10), .x_i(x10),
    .a_o(a10), .b_o(b10), .busy_o(busy10), .done_o(done10),
    .pass_o(pass10), .truth_o(truth10)
  );

  gate_sweep_sequencer #(.HOLD_CYCLES(1), .EXPECTED(T_AND)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .x_i(x1),
    .a_o(a1), .b_o(b1), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .truth_o(truth1)
  );

  // Observation bundle: {busy, done, B, A, PASS, TRUTH[3:0]}
  function automatic logic [8:0] obs_of(input int which);
    if (which == 1) return {busy1, done1, b1, a1, pass1, truth1};
    return {busy10, done10, b10, a10, pass10, truth10};
  endfunction

  // Reference: expected bundle e edges after the edge that accepted START.
  // Vector v occupies edges v*h .. v*h+h-1; its bit is captured at (v+1)*h.
  function automatic logic [8:0] model(input int h, input logic [3:0] tbl,
                                       input int e);
    logic [3:0] mask;
    int         vec;
    if (e < 4 * h) begin
      vec  = e / h;
      mask = 4'b0000;
      for (int j = 0; j < 4; j++) if ((j + 1) * h <= e) mask[j] = 1'b1;
      return {1'b1, 1'b0, 2'(vec), 1'b0, tbl & mask};
    end
    return {1'b0, (e == 4 * h), 2'b00, (tbl == T_AND), tbl};
  endfunction

  function automatic int hold_of(input int which);
    return (which == 1) ? 1 : 10;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 1) start1 = v; else start10 = v;
  endtask

  // Full sweep from the current cycle; START is held for start_len cycles
  // (a large value keeps it high past the end of the sweep).
  task automatic sweep_check(input int which, input logic [3:0] tbl,
                             input int start_len, input string name);
    int         h = hold_of(which);
    int         dones = 0;
    logic [8:0] obs;
    logic [8:0] exp;
    if (which == 1) tbl1 = tbl; else tbl10 = tbl;
    set_start(which, 1'b1);
    for (int e = 0; e <= 4 * h + 1; e++) begin
      @(posedge clk); #1;
      if (e >= start_len - 1) set_start(which, 1'b0);
      obs = obs_of(which);
      exp = model(h, tbl, e);
      if (obs[7]) dones++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s edge %0d: busy,done,b,a,pass,truth got %b want %b",
                 name, e, obs, exp);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d want 1", name, dones);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start10 = 1'b0;
    start1  = 1'b0;
    tbl10   = T_AND;
    tbl1    = T_AND;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_of(0) !== 9'b0) begin
      errors++;
      $display("FAIL reset_dut10: got %b want %b", obs_of(0), 9'b0);
    end
    checks++;
    if (obs_of(1) !== 9'b0) begin
      errors++;
      $display("FAIL reset_dut1: got %b want %b", obs_of(1), 9'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_and_sweep();
    sweep_check(0, T_AND, 1, "and_h10");
  endtask

  task automatic test_or_sweep();
    sweep_check(0, T_OR, 1, "or_h10");
  endtask

  task automatic test_hold_one();
    sweep_check(1, T_AND, 1, "and_h1");
    sweep_check(1, T_XOR, 1, "xor_h1");
  endtask

  task automatic test_stuck_high();
    sweep_check(0, 4'b1111, 1, "stuck1_h10");
  endtask

  task automatic test_start_held();
    logic [8:0] obs;
    logic [8:0] exp;
    int         dones = 0;
    sweep_check(0, T_OR, 30, "start30");
    // Still high after DONE: a second sweep must begin and clear TRUTH/PASS.
    sweep_check(0, T_OR, 1000, "start_long");
    tbl10 = T_AND;
    @(posedge clk); #1;
    start10 = 1'b0;
    obs = obs_of(0);
    checks++;
    if (obs !== 9'b1_0_00_0_0000) begin
      errors++;
      $display("FAIL restart_clear: got %b want %b", obs, 9'b1_0_00_0_0000);
    end
    for (int e = 1; e <= 41; e++) begin
      @(posedge clk); #1;
      obs = obs_of(0);
      exp = model(10, T_AND, e);
      if (obs[7]) dones++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL restart_sweep edge %0d: got %b want %b", e, obs, exp);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [8:0] obs;
    logic [8:0] exp;
    int         dones = 0;
    tbl10   = T_AND;
    start10 = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      @(posedge clk); #1;
      start10 = 1'b0;
    end
    obs = obs_of(0);
    exp = model(10, T_AND, 24);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL pre_reset edge 24: got %b want %b", obs, exp);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    obs = obs_of(0);
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset_immediate: got %b want %b", obs, 9'b0);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(posedge clk); #1;
      obs = obs_of(0);
      if (obs[7]) dones++;
      checks++;
      if (obs !== 9'b0) begin
        errors++;
        $display("FAIL mid_reset_hold %0d: got %b want %b", i, obs, 9'b0);
      end
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d want 0", dones);
    end
    sweep_check(0, T_AND, 1, "post_reset");
  endtask

  task automatic test_random();
    int         which;
    int         h;
    logic [3:0] tbl;
    int         slen;
    for (int i = 0; i < 10; i++) begin
      which = int'($urandom_range(0, 1));
      h     = hold_of(which);
      tbl   = 4'($urandom_range(0, 15));
      slen  = int'($urandom_range(1, 4 * h));
      sweep_check(which, tbl, slen, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_and_sweep();
    test_or_sweep();
    test_hold_one();
    test_stuck_high();
    test_start_held();
    test_reset_mid_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
